mem_port_arbiter: RTL

- Shares one single-ported Avalon-style memory between the CPU instruction-fetch port and the load/store port.
- Sits between the cpu core (o_pc_*, o_ldst_* interfaces) and the on-chip memory.
- Arbitrates each cycle and holds a grant while the memory stalls.
- Returns read data to the requester that owns it, with a fixed memory read latency.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rd_tag_pipe.sv | 35 +++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types for the instruction/load-store memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK_IF = 2'd1,
    LOCK_LS = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/rd_tag_pipe.sv
// ============================================================================
// rd_tag_pipe : DEPTH-deep shift register tracking who owns each read in flight
// Rev 1.0
// ============================================================================
`default_nettype none

module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= '{default: '0};
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one Avalon-style memory between fetch and ld/st
// Optional: ARB_RR_EN selects round-robin tie-break instead of ls-priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   i_if_addr,
  input  logic            i_if_rd,
  input  logic [DW/8-1:0] i_if_byte_en,
  output logic            o_if_waitrequest,
  output logic [DW-1:0]   o_if_rddata,
  output logic            o_if_rddata_valid,
  input  logic [AW-1:0]   i_ls_addr,
  input  logic            i_ls_rd,
  input  logic            i_ls_wr,
  input  logic [DW-1:0]   i_ls_wrdata,
  input  logic [DW/8-1:0] i_ls_byte_en,
  output logic            o_ls_waitrequest,
  output logic [DW-1:0]   o_ls_rddata,
  output logic            o_ls_rddata_valid,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic [DW-1:0]   o_mem_wrdata,
  output logic [DW/8-1:0] o_mem_byte_en,
  input  logic [DW-1:0]   i_mem_rddata,
  input  logic            i_mem_waitrequest
);

  arb_state_t r_state, w_state_nxt;
  logic       w_if_req, w_ls_req, w_if_wins;
  logic       w_grant_if, w_grant_ls, w_rd_accept;
  rd_tag_t    w_tag_in, w_tag_out;

  assign w_if_req = i_if_rd;
  assign w_ls_req = i_ls_rd | i_ls_wr;

`ifdef ARB_RR_EN
  owner_t r_last_grant;

  assign w_if_wins = w_if_req & (~w_ls_req | (r_last_grant == OWN_LS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= OWN_IF;
    end else if (w_grant_if & ~i_mem_waitrequest) begin
      r_last_grant <= OWN_IF;
    end else if (w_grant_ls & ~i_mem_waitrequest) begin
      r_last_grant <= OWN_LS;
    end
  end
`else
  localparam int SCW = $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] r_starve_cnt;

  assign w_if_wins = w_if_req & (~w_ls_req | (r_starve_cnt == SCW'(STARVE_MAX)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_if & ~i_mem_waitrequest) begin
      r_starve_cnt <= '0;
    end else if (w_if_req & ~w_grant_if & (r_starve_cnt != SCW'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // A locked owner that drops its request loses the grant immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_ls  = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_if = w_if_wins;
        w_grant_ls = w_ls_req & ~w_if_wins;
        if (w_grant_if & i_mem_waitrequest)      w_state_nxt = LOCK_IF;
        else if (w_grant_ls & i_mem_waitrequest) w_state_nxt = LOCK_LS;
      end
      LOCK_IF: begin
        w_grant_if = w_if_req;
        if (~w_if_req | ~i_mem_waitrequest) w_state_nxt = IDLE;
      end
      LOCK_LS: begin
        w_grant_ls = w_ls_req;
        if (~w_ls_req | ~i_mem_waitrequest) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (reset) begin
      w_grant_if = 1'b0;
      w_grant_ls = 1'b0;
    end
  end

  assign o_mem_rd      = (w_grant_if & i_if_rd) | (w_grant_ls & i_ls_rd & ~i_ls_wr);
  assign o_mem_wr      = w_grant_ls & i_ls_wr;
  assign o_mem_addr    = w_grant_if ? i_if_addr    : (w_grant_ls ? i_ls_addr    : '0);
  assign o_mem_byte_en = w_grant_if ? i_if_byte_en : (w_grant_ls ? i_ls_byte_en : '0);
  assign o_mem_wrdata  = w_grant_ls ? i_ls_wrdata : '0;

  assign o_if_waitrequest = ~reset & w_if_req & (w_grant_if ? i_mem_waitrequest : 1'b1);
  assign o_ls_waitrequest = ~reset & w_ls_req & (w_grant_ls ? i_mem_waitrequest : 1'b1);

  assign w_rd_accept    = o_mem_rd & ~i_mem_waitrequest;
  assign w_tag_in.valid = w_rd_accept;
  assign w_tag_in.owner = w_grant_if ? OWN_IF : OWN_LS;

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign o_if_rddata       = i_mem_rddata;
  assign o_ls_rddata       = i_mem_rddata;
  assign o_if_rddata_valid = w_tag_out.valid & (w_tag_out.owner == OWN_IF);
  assign o_ls_rddata_valid = w_tag_out.valid & (w_tag_out.owner == OWN_LS);

`ifndef SYNTHESIS
  // Simultaneous load and store is illegal; the store wins.
  a_no_rd_wr: assert property (@(posedge clk) disable iff (reset) !(i_ls_rd && i_ls_wr));
`endif

endmodule

`default_nettype wire
